// File: rtl/alu_flags_pipe.sv
// alu_flags_pipe: registered execute-stage ALU with NZCV flags,
// valid/ready handshakes on both sides and an iterative shift-add multiply.
module alu_flags_pipe #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic             r_outValid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             r_mulCarry;

  logic             w_outFree;
  logic             w_accept;
  logic             w_isMul;
  logic             w_doneLoad;
  logic             w_isSub;
  logic             w_cin;
  logic [WIDTH-1:0] w_opB;
  logic [WIDTH:0]   w_sum;
  logic             w_addV;
  logic [WIDTH-1:0] w_aluResult;
  logic             w_aluC;
  logic             w_aluV;
  logic [3:0]       w_aluFlags;
  logic [3:0]       w_mulFlags;

  assign w_outFree  = !r_outValid || out_ready;
  assign in_ready   = (r_state == S_IDLE) && w_outFree;
  assign w_accept   = in_valid && in_ready;
  assign w_isMul    = MUL_EN && (cmd == 4'b1010);
  assign w_doneLoad = (r_state == S_DONE) && w_outFree;

  assign out_valid  = r_outValid;
  assign result     = r_result;
  assign flags      = r_flags;

  // Shared adder: subtraction is val1 + ~val2 + cin so C comes out as NOT borrow.
  always_comb begin
    w_isSub = (cmd == 4'b0100) || (cmd == 4'b0101);
    w_opB   = w_isSub ? ~val2 : val2;
    w_cin   = 1'b0;
    case (cmd)
      4'b0011: w_cin = carry_in;
      4'b0100: w_cin = 1'b1;
      4'b0101: w_cin = carry_in;
      default: w_cin = 1'b0;
    endcase
    w_sum  = {1'b0, val1} + {1'b0, w_opB} + {{WIDTH{1'b0}}, w_cin};
    w_addV = (val1[WIDTH-1] == w_opB[WIDTH-1]) && (w_sum[WIDTH-1] != val1[WIDTH-1]);
  end

  // Single-cycle result and flags; unknown codes yield zero with C passed through.
  always_comb begin
    w_aluResult = '0;
    w_aluC      = carry_in;
    w_aluV      = 1'b0;
    case (cmd)
      4'b0001: w_aluResult = val2;
      4'b1001: w_aluResult = ~val2;
      4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
        w_aluResult = w_sum[WIDTH-1:0];
        w_aluC      = w_sum[WIDTH];
        w_aluV      = w_addV;
      end
      4'b0110: w_aluResult = val1 & val2;
      4'b0111: w_aluResult = val1 | val2;
      4'b1000: w_aluResult = val1 ^ val2;
      default: w_aluResult = '0;
    endcase
    w_aluFlags = {w_aluResult[WIDTH-1], (w_aluResult == '0), w_aluC, w_aluV};
    w_mulFlags = {r_acc[WIDTH-1], (r_acc == '0), r_mulCarry, 1'b0};
  end

  // Next-state: a multiply walks IDLE -> MUL (WIDTH steps) -> DONE -> IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_isMul) w_nextState = S_MUL;
      S_MUL:  if (r_count == CW'(1)) w_nextState = S_DONE;
      S_DONE: if (w_outFree) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Shift-add multiplier: one multiplier bit consumed per clock while in MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_count    <= '0;
      r_mulCarry <= 1'b0;
    end else if (w_accept && w_isMul) begin
      r_mcand    <= val1;
      r_mplier   <= val2;
      r_acc      <= '0;
      r_count    <= CW'(WIDTH);
      r_mulCarry <= carry_in;
    end else if (r_state == S_MUL) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count - CW'(1);
    end
  end

  // Output register: loads a finished multiply or a single-cycle op, else drains on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_flags    <= 4'b0000;
    end else if (w_doneLoad) begin
      r_outValid <= 1'b1;
      r_result   <= r_acc;
      r_flags    <= w_mulFlags;
    end else if (w_accept && !w_isMul) begin
      r_outValid <= 1'b1;
      r_result   <= w_aluResult;
      r_flags    <= w_aluFlags;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

endmodule
